// File: rtl/sysctrl_tx_serializer.sv
// -----------------------------------------------------------------------------
// sysctrl_tx_serializer
// Captures one system-controller response word and hands it to the UART TX one
// byte at a time, LSB byte first, using a valid/busy handshake per byte. A
// one-cycle tx_done pulse follows the completion of the final byte.
//
// Optional feature macro: SYSCTRL_TXSER_CHECKSUM_EN
//   When defined, an extra byte holding the XOR of all payload bytes is sent
//   after the payload (a zero-length word sends a single 0x00 checksum byte).
//
// Ports:
//   clk            system clock, rising edge
//   RST            asynchronous active-low reset
//   in_valid       response word offered
//   in_ready       serializer idle and able to accept a word
//   in_data        2*DATA_WIDTH payload, byte 0 = in_data[7:0]
//   in_nbytes      payload byte count, clamped to DATA_WIDTH/4 at capture
//   tx_p_data      byte presented to the UART TX (holds between bytes)
//   tx_data_valid  tx_p_data valid, held until UART busy is sampled
//   tx_busy        UART TX busy
//   tx_done        one-cycle pulse after the last byte completes
//   byte_idx       index of the byte currently in flight
// -----------------------------------------------------------------------------
module sysctrl_tx_serializer #(
  parameter  int unsigned DATA_WIDTH = 32,
  localparam int unsigned NB_W       = $clog2(DATA_WIDTH / 4) + 1
) (
  input  logic                    clk,
  input  logic                    RST,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2*DATA_WIDTH-1:0] in_data,
  input  logic [NB_W-1:0]         in_nbytes,
  output logic [7:0]              tx_p_data,
  output logic                    tx_data_valid,
  input  logic                    tx_busy,
  output logic                    tx_done,
  output logic [NB_W-1:0]         byte_idx
);

  localparam int unsigned PW     = 2 * DATA_WIDTH;
  localparam int unsigned MAX_NB = DATA_WIDTH / 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESENT   = 2'd1,
    WAIT_DONE = 2'd2,
    DONE      = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   shift_q, shift_d;
  logic [NB_W-1:0] count_q, count_d;
  logic [NB_W-1:0] idx_q, idx_d;
  logic [NB_W-1:0] nb_clamped;
  logic [NB_W-1:0] idx_inc;

  logic            in_ready_q, in_ready_d;
  logic            valid_q, valid_d;
  logic            done_q, done_d;
  logic [7:0]      pdata_q, pdata_d;

`ifdef SYSCTRL_TXSER_CHECKSUM_EN
  logic [7:0]      csum_q, csum_d;
  logic [7:0]      csum_next;
  logic            chk_q, chk_d;
`endif

  // Requested byte count limited to the widest (ALU) response
  assign nb_clamped = (in_nbytes > NB_W'(MAX_NB)) ? NB_W'(MAX_NB) : in_nbytes;
  assign idx_inc    = idx_q + NB_W'(1);

  // State register
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    count_d = count_q;
    idx_d   = idx_q;
`ifdef SYSCTRL_TXSER_CHECKSUM_EN
    csum_d    = csum_q;
    chk_d     = chk_q;
    csum_next = csum_q ^ shift_q[7:0];
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          shift_d = in_data;
          count_d = nb_clamped;
          idx_d   = '0;
`ifdef SYSCTRL_TXSER_CHECKSUM_EN
          csum_d  = '0;
          chk_d   = 1'b0;
          state_d = PRESENT;
          // Empty word: only the (zero) checksum byte goes out
          if (nb_clamped == '0) begin
            shift_d = '0;
            chk_d   = 1'b1;
          end
`else
          state_d = (nb_clamped == '0) ? DONE : PRESENT;
`endif
        end
      end
      PRESENT: begin
        // Busy already high on entry also counts as the byte being taken
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
`ifdef SYSCTRL_TXSER_CHECKSUM_EN
          if (chk_q) begin
            state_d = DONE;
          end else begin
            csum_d  = csum_next;
            shift_d = shift_q >> 8;
            idx_d   = idx_inc;
            state_d = PRESENT;
            // Payload exhausted: the checksum byte rides at index count
            if (idx_inc == count_q) begin
              shift_d = PW'(csum_next);
              chk_d   = 1'b1;
            end
          end
`else
          shift_d = shift_q >> 8;
          idx_d   = idx_inc;
          state_d = (idx_inc == count_q) ? DONE : PRESENT;
`endif
        end
      end
      DONE: begin
        idx_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs follow the state being entered
  always_comb begin
    in_ready_d = (state_d == IDLE);
    valid_d    = (state_d == PRESENT);
    done_d     = (state_d == DONE);
    pdata_d    = (state_d == PRESENT) ? shift_d[7:0] : pdata_q;
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      shift_q    <= '0;
      count_q    <= '0;
      idx_q      <= '0;
      in_ready_q <= 1'b1;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      pdata_q    <= '0;
`ifdef SYSCTRL_TXSER_CHECKSUM_EN
      csum_q     <= '0;
      chk_q      <= 1'b0;
`endif
    end else begin
      shift_q    <= shift_d;
      count_q    <= count_d;
      idx_q      <= idx_d;
      in_ready_q <= in_ready_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      pdata_q    <= pdata_d;
`ifdef SYSCTRL_TXSER_CHECKSUM_EN
      csum_q     <= csum_d;
      chk_q      <= chk_d;
`endif
    end
  end

  assign in_ready      = in_ready_q;
  assign tx_data_valid = valid_q;
  assign tx_done       = done_q;
  assign tx_p_data     = pdata_q;
  assign byte_idx      = idx_q;

endmodule
